// File: rtl/keypad_entry.sv
// Keypad operand entry: synchronises and debounces key presses, decodes them and
// maintains a signed 16-bit entry. Debounce FSM states are built only with ENTRY_DEBOUNCE_EN.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] value,
  output logic [2:0]  digit_count,
  output logic        overflow,
  output logic        entered,
  output logic [15:0] entered_value,
  output logic        clr_out
);

`ifdef ENTRY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, DEB_PRESS, ACCEPT, WAIT_REL, DEB_REL} state_t;
  logic [CW-1:0] deb_cnt;
`else
  typedef enum logic [1:0] {IDLE, ACCEPT, WAIT_REL} state_t;
`endif

  state_t      state;
  logic        sync1, sync2;
  logic [15:0] mag;
  logic        sign;
  logic        fresh;

  logic [15:0] eff_mag;
  logic        eff_sign;
  logic [2:0]  eff_count;
  logic [19:0] digit_sum;
  logic        digit_reject;
  logic [15:0] bs_mag;

  // A digit arriving after enter starts from a cleared entry.
  always_comb begin
    eff_mag      = fresh ? 16'd0 : mag;
    eff_sign     = fresh ? 1'b0  : sign;
    eff_count    = fresh ? 3'd0  : digit_count;
    digit_sum    = 20'(eff_mag) * 20'd10 + 20'(key_code);
    digit_reject = (eff_count == 3'(MAX_DIGITS)) ||
                   (!eff_sign && digit_sum > 20'd32767) ||
                   (eff_sign  && digit_sum > 20'd32768);
    bs_mag       = mag / 16'd10;
  end

  assign value = sign ? (~mag + 16'd1) : mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      mag           <= '0;
      sign          <= 1'b0;
      fresh         <= 1'b0;
      digit_count   <= '0;
      overflow      <= 1'b0;
      entered       <= 1'b0;
      entered_value <= '0;
      clr_out       <= 1'b0;
`ifdef ENTRY_DEBOUNCE_EN
      deb_cnt       <= '0;
`endif
    end else begin
      sync1   <= key_valid;
      sync2   <= sync1;
      entered <= 1'b0;
      clr_out <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
`ifdef ENTRY_DEBOUNCE_EN
            state   <= DEB_PRESS;
            deb_cnt <= '0;
`else
            state   <= ACCEPT;
`endif
          end
        end
`ifdef ENTRY_DEBOUNCE_EN
        DEB_PRESS: begin
          if (!sync2)                   state <= IDLE;
          else if (deb_cnt == CNT_LAST) state <= ACCEPT;
          else                          deb_cnt <= deb_cnt + 1'b1;
        end
        DEB_REL: begin
          if (sync2)                    state <= WAIT_REL;
          else if (deb_cnt == CNT_LAST) state <= IDLE;
          else                          deb_cnt <= deb_cnt + 1'b1;
        end
`endif
        ACCEPT: begin
          state <= WAIT_REL;
          if (key_code <= 4'd9) begin
            fresh <= 1'b0;
            sign  <= eff_sign;
            if (digit_reject) begin
              mag         <= eff_mag;
              digit_count <= eff_count;
              overflow    <= 1'b1;
            end else begin
              mag         <= digit_sum[15:0];
              overflow    <= fresh ? 1'b0 : overflow;
              // Leading zeros do not count as significant digits.
              digit_count <= (eff_mag == 16'd0 && key_code == 4'd0) ? eff_count : eff_count + 3'd1;
            end
          end else begin
            case (key_code)
              4'd10: begin
                fresh <= 1'b0;
                if (mag == 16'h8000 && sign) overflow <= 1'b1;
                else                         sign     <= ~sign;
              end
              4'd11: begin
                fresh       <= 1'b0;
                mag         <= bs_mag;
                overflow    <= 1'b0;
                digit_count <= (digit_count == 3'd0) ? 3'd0 : digit_count - 3'd1;
                if (bs_mag == 16'd0) sign <= 1'b0;
              end
              4'd12: begin
                mag           <= '0;
                sign          <= 1'b0;
                fresh         <= 1'b0;
                digit_count   <= '0;
                overflow      <= 1'b0;
                entered_value <= '0;
                clr_out       <= 1'b1;
              end
              4'd13: begin
                entered       <= 1'b1;
                entered_value <= value;
                fresh         <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        WAIT_REL: begin
          if (!sync2) begin
`ifdef ENTRY_DEBOUNCE_EN
            state   <= DEB_REL;
            deb_cnt <= '0;
`else
            state   <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
